// File: rtl/cache_perf_counter_if.sv
// Request-stream, control and snapshot-readout bundle for cache_perf_counter.
// master = monitor/debug side, slave = counter unit.
interface cache_perf_counter_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             clr;
    logic             snap;
    logic             req_valid;
    logic             req_write;
    logic             stall;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             hit_pulse;
    logic             miss_pulse;

    modport master (
        output en, clr, snap,
        output req_valid, req_write, stall,
        output rd_sel,
        input  rd_data, hit_pulse, miss_pulse
    );

    modport slave (
        input  en, clr, snap,
        input  req_valid, req_write, stall,
        input  rd_sel,
        output rd_data, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/cache_perf_counter.sv
// L1 cache/CMU performance counters with snapshot bank and miss latency.
// Define CACHE_PERF_SAT_EN to make event counters saturate instead of wrap.
module cache_perf_counter #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    cache_perf_counter_if.slave bus
);
    localparam int N_CNT = 6;

    logic [CNT_W-1:0] cnt_q  [N_CNT];
    logic [CNT_W-1:0] snap_q [N_CNT];
    logic [LAT_W-1:0] max_lat;
    logic [LAT_W-1:0] snap_lat;
    logic [LAT_W-1:0] cur_lat;
    logic             pend;
    logic             hit_q;
    logic             miss_q;
    logic [CNT_W-1:0] rd_mux;

    logic             stall_cyc;
    logic             complete;
    logic             hit;
    logic             miss;
    logic [N_CNT-1:0] ev;

    assign stall_cyc = bus.req_valid & bus.stall;
    assign complete  = bus.req_valid & ~bus.stall;
    assign hit       = complete & ~pend;
    assign miss      = complete & pend;

    // Event order matches the rd_sel encoding 0..5.
    assign ev = {
        stall_cyc,
        miss,
        hit & bus.req_write,
        hit & ~bus.req_write,
        complete,
        bus.req_valid
    };

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] c,
        input logic             e
    );
`ifdef CACHE_PERF_SAT_EN
        if (e && (c != {CNT_W{1'b1}}))
            return c + CNT_W'(1);
        return c;
`else
        return c + CNT_W'(e);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
            max_lat  <= '0;
            snap_lat <= '0;
            cur_lat  <= '0;
            pend     <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            // Snapshot takes pre-increment, pre-clear values.
            if (bus.snap) begin
                for (int i = 0; i < N_CNT; i++)
                    snap_q[i] <= cnt_q[i];
                snap_lat <= max_lat;
            end

            if (bus.clr) begin
                for (int i = 0; i < N_CNT; i++)
                    cnt_q[i] <= '0;
                max_lat <= '0;
            end else if (bus.en) begin
                for (int i = 0; i < N_CNT; i++)
                    cnt_q[i] <= bump(cnt_q[i], ev[i]);
                if (miss && (cur_lat > max_lat))
                    max_lat <= cur_lat;
            end

            hit_q  <= hit;
            miss_q <= miss;

            // Request tracking ignores en/clr so straddling requests classify right.
            if (stall_cyc) begin
                pend <= 1'b1;
                if (cur_lat != {LAT_W{1'b1}})
                    cur_lat <= cur_lat + LAT_W'(1);
            end else if (complete) begin
                pend    <= 1'b0;
                cur_lat <= '0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (bus.rd_sel < 3'd6):  rd_mux = snap_q[bus.rd_sel];
            (bus.rd_sel == 3'd6): rd_mux = CNT_W'(snap_lat);
            default:              rd_mux = '0;
        endcase
    end

    assign bus.rd_data    = rd_mux;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
endmodule

// File: tb/tb_cache_perf_counter.sv
// Random + directed bench for cache_perf_counter against an event-count model.
// Runs a 32-bit and a 4-bit counter instance on identical stimulus.
module tb_cache_perf_counter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_perf_counter_if #(.CNT_W(32)) bus ();
    cache_perf_counter_if #(.CNT_W(4))  sbus ();

    cache_perf_counter #(.CNT_W(32), .LAT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    cache_perf_counter #(.CNT_W(4), .LAT_W(8)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    always_comb begin
        sbus.en        = bus.en;
        sbus.clr       = bus.clr;
        sbus.snap      = bus.snap;
        sbus.req_valid = bus.req_valid;
        sbus.req_write = bus.req_write;
        sbus.stall     = bus.stall;
        sbus.rd_sel    = bus.rd_sel;
    end

    int n_chk = 0;
    int n_err = 0;
    int hp_cnt = 0;
    int mp_cnt = 0;
    bit started = 0;

    // Model: unbounded event counts since last clr; width applied on readout.
    longint m_cnt [6];
    longint m_snap [6];
    int     m_ml, m_snap_ml, m_cur;
    bit     m_pend, m_hp, m_mp;

    always @(posedge clk) begin
        bit v, s, cpl, h, m;
        v   = bus.req_valid;
        s   = bus.stall;
        cpl = v && !s;
        h   = cpl && !m_pend;
        m   = cpl && m_pend;
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_cnt[i]  = 0;
                m_snap[i] = 0;
            end
            m_ml = 0; m_snap_ml = 0; m_cur = 0;
            m_pend = 0; m_hp = 0; m_mp = 0;
            started = 1;
        end else begin
            if (bus.snap) begin
                for (int i = 0; i < 6; i++)
                    m_snap[i] = m_cnt[i];
                m_snap_ml = m_ml;
            end
            if (bus.clr) begin
                for (int i = 0; i < 6; i++)
                    m_cnt[i] = 0;
                m_ml = 0;
            end else if (bus.en) begin
                m_cnt[0] += longint'(v);
                m_cnt[1] += longint'(cpl);
                m_cnt[2] += longint'(h && !bus.req_write);
                m_cnt[3] += longint'(h && bus.req_write);
                m_cnt[4] += longint'(m);
                m_cnt[5] += longint'(v && s);
                if (m && m_cur > m_ml)
                    m_ml = m_cur;
            end
            m_hp = h;
            m_mp = m;
            if (v && s) begin
                m_pend = 1;
                m_cur  = (m_cur < 255) ? m_cur + 1 : 255;
            end else if (cpl) begin
                m_pend = 0;
                m_cur  = 0;
            end
        end
    end

    function automatic logic [31:0] exp_rd(int w, logic [2:0] sel);
        longint mx, c;
        mx = (longint'(1) << w) - 1;
        if (sel < 6) begin
            c = m_snap[sel];
`ifdef CACHE_PERF_SAT_EN
            return 32'(c > mx ? mx : c);
`else
            return 32'(c & mx);
`endif
        end
        if (sel == 6)
            return 32'(longint'(m_snap_ml) & mx);
        return 32'd0;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("rd_data32", bus.rd_data, exp_rd(32, bus.rd_sel));
            check("rd_data4", {28'd0, sbus.rd_data}, exp_rd(4, bus.rd_sel));
            check("hit_pulse", 32'(bus.hit_pulse), 32'(m_hp));
            check("miss_pulse", 32'(bus.miss_pulse), 32'(m_mp));
        end
        if (bus.hit_pulse)  hp_cnt++;
        if (bus.miss_pulse) mp_cnt++;
    end

    task automatic idle();
        bus.req_valid = 0;
        bus.req_write = 0;
        bus.stall     = 0;
        bus.en        = 1;
        bus.clr       = 0;
        bus.snap      = 0;
    endtask

    task automatic step(bit v, bit w, bit s, bit e, bit c, bit sn);
        bus.req_valid = v;
        bus.req_write = w;
        bus.stall     = s;
        bus.en        = e;
        bus.clr       = c;
        bus.snap      = sn;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rep(int n, bit v, bit w, bit s, bit e);
        for (int i = 0; i < n; i++)
            step(v, w, s, e, 0, 0);
    endtask

    task automatic lit(string nm, logic [2:0] sel, logic [31:0] exp);
        bus.rd_sel = sel;
        @(negedge clk);
        check(nm, bus.rd_data, exp);
    endtask

    task automatic clear_all();
        step(0, 0, 0, 1, 1, 0);
        #1;
        hp_cnt = 0;
        mp_cnt = 0;
    endtask

    initial begin
        idle();
        bus.rd_sel = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        lit("rst_cyc", 0, 0);
        lit("rst_lat", 6, 0);
        check("rst_hp", 32'(bus.hit_pulse), 0);
        rst = 0;
        @(posedge clk);
        #1;
        hp_cnt = 0;
        mp_cnt = 0;

        rep(4, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        lit("t1_cyc", 0, 4);
        lit("t1_req", 1, 4);
        lit("t1_rdhit", 2, 4);
        lit("t1_wrhit", 3, 0);
        lit("t1_miss", 4, 0);
        #1;
        check("t1_hpcnt", 32'(hp_cnt), 4);

        clear_all();
        rep(5, 1, 1, 1, 1);
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        lit("t2_miss", 4, 1);
        lit("t2_stall", 5, 5);
        lit("t2_cyc", 0, 6);
        lit("t2_req", 1, 1);
        lit("t2_lat", 6, 5);
        #1;
        check("t2_mpcnt", 32'(mp_cnt), 1);

        clear_all();
        rep(3, 1, 0, 1, 1); step(1, 0, 0, 1, 0, 0);
        rep(7, 1, 1, 1, 1); step(1, 1, 0, 1, 0, 0);
        rep(2, 1, 0, 1, 1); step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        lit("t3_lat", 6, 7);
        lit("t3_stall", 5, 12);
        lit("t3_miss", 4, 3);

        clear_all();
        rep(2, 1, 0, 1, 1);
        rep(3, 1, 0, 1, 0);
        rep(2, 1, 0, 1, 1);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        lit("t4_miss", 4, 1);
        lit("t4_stall", 5, 4);
        lit("t4_cyc", 0, 5);
        lit("t4_lat", 6, 7);

        clear_all();
        rep(10, 1, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1);
        lit("t5_snapreq", 1, 10);
        step(0, 0, 0, 1, 0, 1);
        lit("t5_livereq", 1, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        lit("t5_nextreq", 1, 1);

        clear_all();
        rep(17, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        bus.rd_sel = 1;
        @(negedge clk);
`ifdef CACHE_PERF_SAT_EN
        check("t6_req4", {28'd0, sbus.rd_data}, 15);
`else
        check("t6_req4", {28'd0, sbus.rd_data}, 1);
`endif

        clear_all();
        rep(300, 1, 1, 1, 1);
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        lit("lat_sat", 6, 255);

        rep(2, 1, 0, 1, 1);
        rst = 1;
        step(0, 0, 0, 1, 0, 0);
        rst = 0;
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        lit("rst_mid_hit", 2, 1);
        lit("rst_mid_miss", 4, 0);

        for (int i = 0; i < 4000; i++) begin
            bus.rd_sel = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
